conv_fmap_pool_reader: RTL

- Consumer at the far end of the convolution stage's go/flag handshake.
- Waits for the convolution-done flag, then reads the finished 4x64x64 sign-magnitude feature map through a synchronous read port.
- Applies ReLU and 2x2 stride-2 max-pooling to the map.
- Streams the 4x32x32 pooled result downstream on a valid/ready interface, then pulses done.

---
 rtl/conv_fmap_pool_reader_pkg.sv | 25 ++
 rtl/conv_fmap_pool_reader_if.sv | 30 +++
 rtl/conv_fmap_pool_reader_sm_relu_max.sv | 18 +
 rtl/conv_fmap_pool_reader.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/conv_fmap_pool_reader_pkg.sv
// Shared constants, word type and FSM state encoding for the pooled feature-map reader.
package cnn_pkg;
  localparam int unsigned N      = 35;
  localparam int unsigned Q      = 32;
  localparam int unsigned CH     = 4;
  localparam int unsigned H      = 64;
  localparam int unsigned W      = 64;
  localparam int unsigned POOL   = 2;
  localparam int unsigned OH     = H / POOL;
  localparam int unsigned OW     = W / POOL;
  localparam int unsigned CH_W   = $clog2(CH);
  localparam int unsigned ROW_W  = $clog2(H);
  localparam int unsigned COL_W  = $clog2(W);
  localparam int unsigned OROW_W = $clog2(OH);
  localparam int unsigned OCOL_W = $clog2(OW);

  typedef logic [N-1:0] fixed_t;

  typedef enum logic [2:0] {IDLE, FETCH, LAST, EMIT, DONE} state_t;

  // Sign-magnitude ReLU: any negative value, including negative zero, becomes +0.
  function automatic fixed_t relu(input fixed_t v);
    return v[N-1] ? '0 : v;
  endfunction
endpackage

// File: rtl/conv_fmap_pool_reader_if.sv
// Read port towards the feature-map store plus the pooled valid/ready output stream.
interface conv_fmap_pool_reader_if;
  import cnn_pkg::*;

  logic              rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  fixed_t            rd_data;
  logic              out_valid;
  logic              out_ready;
  fixed_t            out_data;
  logic [CH_W-1:0]   out_ch;
  logic [OROW_W-1:0] out_row;
  logic [OCOL_W-1:0] out_col;

  modport master (
    output rd_en, rd_ch, rd_row, rd_col,
    input  rd_data,
    output out_valid, out_data, out_ch, out_row, out_col,
    input  out_ready
  );

  modport slave (
    input  rd_en, rd_ch, rd_row, rd_col,
    output rd_data,
    input  out_valid, out_data, out_ch, out_row, out_col,
    output out_ready
  );
endinterface

// File: rtl/conv_fmap_pool_reader_sm_relu_max.sv
// Combinational ReLU + max of a running maximum and one new sign-magnitude word.
module sm_relu_max
  import cnn_pkg::*;
(
  input  fixed_t run_max,
  input  fixed_t new_word,
  output fixed_t max_out
);
  fixed_t a;
  fixed_t b;

  // Rectify both operands, then keep the larger magnitude (sign is always 0 afterwards).
  always_comb begin
    a       = relu(run_max);
    b       = relu(new_word);
    max_out = (b[N-2:0] > a[N-2:0]) ? b : a;
  end
endmodule

// File: rtl/conv_fmap_pool_reader.sv
// Reads the finished feature map window by window, applies ReLU + 2x2 max-pool and
// streams the pooled words out on a valid/ready interface.
module conv_fmap_pool_reader
  import cnn_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    conv_flag,
  conv_fmap_pool_reader_if.master bus,
  output logic                    busy,
  output logic                    done
);
  state_t            state_q, state_d;
  logic              flag_q, flag_d;
  logic [1:0]        k_q, k_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [OROW_W-1:0] pr_q, pr_d;
  logic [OCOL_W-1:0] pc_q, pc_d;
  fixed_t            max_q, max_d, max_next;
  fixed_t            out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [OROW_W-1:0] out_row_q, out_row_d;
  logic [OCOL_W-1:0] out_col_q, out_col_d;
  logic              start;
  logic              last_win;

  assign start    = conv_flag & ~flag_q;
  assign last_win = (ch_q == CH_W'(CH - 1)) && (pr_q == OROW_W'(OH - 1)) &&
                    (pc_q == OCOL_W'(OW - 1));

  sm_relu_max u_relu_max (
    .run_max  (max_q),
    .new_word (bus.rd_data),
    .max_out  (max_next)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: four reads, one capture cycle, then hold until accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (k_q == 2'd3) state_d = LAST;
      LAST:    state_d = EMIT;
      EMIT:    if (bus.out_ready) state_d = last_win ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; read address only presented while fetching.
  always_comb begin
    bus.rd_en  = 1'b0;
    bus.rd_ch  = '0;
    bus.rd_row = '0;
    bus.rd_col = '0;
    if (state_q == FETCH) begin
      bus.rd_en  = 1'b1;
      bus.rd_ch  = ch_q;
      bus.rd_row = {pr_q, k_q[1]};
      bus.rd_col = {pc_q, k_q[0]};
    end
    bus.out_valid = (state_q == EMIT);
    busy          = (state_q == FETCH) || (state_q == LAST) || (state_q == EMIT);
    done          = (state_q == DONE);
  end

  assign bus.out_data = out_data_q;
  assign bus.out_ch   = out_ch_q;
  assign bus.out_row  = out_row_q;
  assign bus.out_col  = out_col_q;

  // Datapath next values: sub-counter, running max, pooled result and window counters.
  always_comb begin
    flag_d     = conv_flag;
    k_d        = k_q;
    ch_d       = ch_q;
    pr_d       = pr_q;
    pc_d       = pc_q;
    max_d      = max_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d  = '0;
          ch_d = '0;
          pr_d = '0;
          pc_d = '0;
        end
      end
      FETCH: begin
        k_d = k_q + 2'd1;
        // rd_data is stale on k=0, so the window max restarts from +0 there.
        max_d = (k_q == 2'd0) ? '0 : max_next;
      end
      LAST: begin
        out_data_d = max_next;
        out_ch_d   = ch_q;
        out_row_d  = pr_q;
        out_col_d  = pc_q;
      end
      EMIT: begin
        if (bus.out_ready) begin
          pc_d = pc_q + 1'b1;
          if (pc_q == OCOL_W'(OW - 1)) begin
            pr_d = pr_q + 1'b1;
            if (pr_q == OROW_W'(OH - 1)) ch_d = ch_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flag_q     <= 1'b0;
      k_q        <= '0;
      ch_q       <= '0;
      pr_q       <= '0;
      pc_q       <= '0;
      max_q      <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
    end else begin
      flag_q     <= flag_d;
      k_q        <= k_d;
      ch_q       <= ch_d;
      pr_q       <= pr_d;
      pc_q       <= pc_d;
      max_q      <= max_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
    end
  end
endmodule
